// File: rtl/program_counter.sv
// rtl/program_counter.sv - SAP-1 program counter with tri-state bus output (optional PC_LOAD_EN jump load)
module program_counter #(
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
`ifdef PC_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
`endif
    input  logic             enable,
    input  logic             cp,
    output logic [WIDTH-1:0] w_bus
);

    // Oversized reset values keep only their low WIDTH bits.
    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] pc;

`ifdef PC_LOAD_EN
    // Async reset wins, then a jump load, then the count pulse; wraps silently at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (cp) begin
            pc <= pc + 1'b1;
        end
    end
`else
    // Async reset wins over the count pulse; the count wraps silently at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else if (cp) begin
            pc <= pc + 1'b1;
        end
    end
`endif

    // Bus driver has no register stage, so enable acts in the same cycle and reset never touches it.
    assign w_bus = enable ? pc : {WIDTH{1'bz}};

endmodule

// File: tb/tb_program_counter.sv
// tb/tb_program_counter.sv - directed self-checking bench for program_counter
`timescale 1ns/1ps
module tb_program_counter;

    localparam int W = 4;
    // Released bus: pulled-up copy reads all ones, pulled-down copy reads all zeros.
    localparam logic [2*W-1:0] EXP_Z = 8'hF0;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         cp = 1'b0;
`ifdef PC_LOAD_EN
    logic         load = 1'b0;
    logic [W-1:0] load_addr = '0;
`endif

    tri1 [W-1:0]  bus_up;
    tri0 [W-1:0]  bus_dn;
    wire [2*W-1:0] obs = {bus_up, bus_dn};

    int n_checks = 0;
    int n_pass = 0;

    always #1 clk = ~clk;

    program_counter #(.WIDTH(W), .RESET_VALUE(0)) u_dut_up (
        .clk      (clk),
        .reset    (reset),
`ifdef PC_LOAD_EN
        .load     (load),
        .load_addr(load_addr),
`endif
        .enable   (enable),
        .cp       (cp),
        .w_bus    (bus_up)
    );

    program_counter #(.WIDTH(W), .RESET_VALUE(0)) u_dut_dn (
        .clk      (clk),
        .reset    (reset),
`ifdef PC_LOAD_EN
        .load     (load),
        .load_addr(load_addr),
`endif
        .enable   (enable),
        .cp       (cp),
        .w_bus    (bus_dn)
    );

    function automatic logic [2*W-1:0] exp_val(input logic [W-1:0] v);
        return {v, v};
    endfunction

    task automatic test_reset();
        reset  = 1'b0;
        enable = 1'b1;
        cp     = 1'b0;
        #0.5;
        n_checks++;
        if (obs !== exp_val(4'd0)) $display("FAIL reset_before_edge: got %b want %b", obs, exp_val(4'd0));
        else n_pass++;
        #3.0;
        n_checks++;
        if (obs !== exp_val(4'd0)) $display("FAIL reset_held: got %b want %b", obs, exp_val(4'd0));
        else n_pass++;
        #0.5;
        reset = 1'b1;
    endtask

    task automatic test_count();
        @(negedge clk);
        enable = 1'b0;
        cp     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== EXP_Z) $display("FAIL count_hiz_%0d: got %b want %b", i, obs, EXP_Z);
            else n_pass++;
        end
        cp     = 1'b0;
        enable = 1'b1;
        #0.1;
        n_checks++;
        if (obs !== exp_val(4'd5)) $display("FAIL count_5: got %b want %b", obs, exp_val(4'd5));
        else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        #0.2 reset = 1'b0;
        #0.2 reset = 1'b1;
        cp     = 1'b1;
        enable = 1'b1;
        repeat (15) @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd15)) $display("FAIL wrap_15: got %b want %b", obs, exp_val(4'd15));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd0)) $display("FAIL wrap_16: got %b want %b", obs, exp_val(4'd0));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd1)) $display("FAIL wrap_17: got %b want %b", obs, exp_val(4'd1));
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        #0.2 reset = 1'b0;
        #0.2 reset = 1'b1;
        cp     = 1'b1;
        enable = 1'b1;
        repeat (7) @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd7)) $display("FAIL midrst_7: got %b want %b", obs, exp_val(4'd7));
        else n_pass++;
        #0.25 reset = 1'b0;
        #0.25;
        n_checks++;
        if (obs !== exp_val(4'd0)) $display("FAIL midrst_immediate: got %b want %b", obs, exp_val(4'd0));
        else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd1)) $display("FAIL midrst_after_edge: got %b want %b", obs, exp_val(4'd1));
        else n_pass++;
    endtask

    task automatic test_hold_tristate();
        cp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            enable = (i % 2 == 0);
            #1.5;
            n_checks++;
            if (enable && obs !== exp_val(4'd1)) $display("FAIL hold_on_%0d: got %b want %b", i, obs, exp_val(4'd1));
            else if (!enable && obs !== EXP_Z) $display("FAIL hold_off_%0d: got %b want %b", i, obs, EXP_Z);
            else n_pass++;
            #1.5;
        end
        enable = 1'b1;
        #0.1;
        n_checks++;
        if (obs !== exp_val(4'd1)) $display("FAIL hold_final: got %b want %b", obs, exp_val(4'd1));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        enable = 1'b1;
        cp     = 1'b1;
        #0.8;
        n_checks++;
        if (obs !== exp_val(4'd1)) $display("FAIL b2b_pre_edge: got %b want %b", obs, exp_val(4'd1));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd2)) $display("FAIL b2b_edge1: got %b want %b", obs, exp_val(4'd2));
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd3)) $display("FAIL b2b_edge2: got %b want %b", obs, exp_val(4'd3));
        else n_pass++;
        cp = 1'b0;
    endtask

`ifdef PC_LOAD_EN
    task automatic test_load();
        #0.2 reset = 1'b0;
        #0.2 reset = 1'b1;
        enable = 1'b1;
        cp     = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd3)) $display("FAIL load_pre: got %b want %b", obs, exp_val(4'd3));
        else n_pass++;
        load      = 1'b1;
        load_addr = 4'd12;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd12)) $display("FAIL load_jump: got %b want %b", obs, exp_val(4'd12));
        else n_pass++;
        load = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs !== exp_val(4'd13)) $display("FAIL load_next: got %b want %b", obs, exp_val(4'd13));
        else n_pass++;
        cp = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_mid_reset();
        test_hold_tristate();
        test_back_to_back();
`ifdef PC_LOAD_EN
        test_load();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 Parameter: WIDTH, default 4, counter and bus width in bits (SAP-1 address width).
REQ-002 Parameter: RESET_VALUE, default 0, count loaded on reset; values of 2**WIDTH or more are truncated to WIDTH bits.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  system clock, rising-edge active.
REQ-005 Port: reset  input  1  asynchronous active-low reset; 0 clears the counter.
REQ-006 Port: enable  input  1  output enable (Ep); 1 drives the count onto w_bus.
REQ-007 Port: cp  input  1  count pulse (Cp); 1 increments the count on the next rising clk edge.
REQ-008 Port: w_bus  output  WIDTH  tri-state bus output; high-Z when not enabled.

Function
REQ-009 The block SHALL hold an internal WIDTH-bit register, pc, which is the only state.
REQ-010 On a rising clk edge with reset=1 and cp=1, pc SHALL become (pc+1) mod 2**WIDTH.
REQ-011 On a rising clk edge with cp=0, pc SHALL hold its value.
REQ-012 Wrap-around: with WIDTH=4, pc=15 and cp=1, pc SHALL become 0 on the edge; no flag, no stall.
REQ-013 w_bus SHALL equal pc combinationally while enable=1 and SHALL be high-Z on all bits while enable=0; there is no clock latency on enable.
REQ-014 The enable input SHALL NOT affect pc.
REQ-015 With enable=1 and cp=1 together, w_bus SHALL show the pre-edge pc until the edge, then the incremented value.
REQ-016 The X/Z value of cp SHALL be treated as 0 for counting; counting SHALL be purely synchronous to clk.

Reset
REQ-017 reset=0 SHALL force pc to RESET_VALUE immediately, without waiting for a clock edge, and SHALL hold it there while low.
REQ-018 Reset SHALL take priority over cp and the load path.
REQ-019 The first rising clk edge after reset deasserts SHALL obey the normal rules (pc increments if cp=1).
REQ-020 Reset SHALL NOT drive w_bus; w_bus SHALL follow enable during reset and show RESET_VALUE if enable=1.
REQ-021 Reset asserted mid-count SHALL discard the current count; there is no pending-increment memory.

Configuration
REQ-022 Macro PC_LOAD_EN: when defined, the module SHALL add the ports load (input, 1 bit) and load_addr (input, WIDTH bits).
REQ-023 With PC_LOAD_EN defined, a rising edge with load=1 SHALL set pc to load_addr, and load SHALL take priority over cp.
REQ-024 Without PC_LOAD_EN defined, these ports SHALL be absent and the behaviour SHALL be exactly REQ-009 to REQ-021.

Verification
REQ-025 Reset scenario: reset=0 for 4 ns with cp=0 and enable=1 -> w_bus=0 throughout, including before the first clk edge.
REQ-026 Count scenario: clk period 2 ns; cp=1 for 5 rising edges with enable=0 -> w_bus stays ZZZZ; then enable=1 -> w_bus=5.
REQ-027 Wrap scenario: 16 edges with cp=1 starting from 0 -> w_bus=0; 17 edges -> w_bus=1.
REQ-028 Mid-count reset scenario: count to 7, then pulse reset=0 between clock edges -> w_bus=0 at once; with cp=1 after release, w_bus=1 after the next edge.
REQ-029 Hold and tri-state scenario: cp=0 with enable toggled every 3 ns -> w_bus alternates between the held pc and ZZZZ; pc is unchanged.
REQ-030 Load scenario (PC_LOAD_EN defined): pc=3, load=1, load_addr=12, cp=1 at one edge -> w_bus=12; the next edge with cp=1 and load=0 -> w_bus=13.
